pipeline_stall_ctrl: RTL and testbench
======================================

# pipeline_stall_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It collects stall requests from the ID, EX and MEM stages and produces the shared 6-bit `control` vector consumed by the PC and by every inter-stage pipeline register, including MEM→WB. It also owns the counted multi-cycle EX stall used by the iterative divider/multiplier, and the exception flush/redirect. A free-running stall-cycle performance counter is included.

## Interface
Parameters:
- `CNT_W`, default 6: width of the multi-cycle stall count.
- `PERF_W`, default 32: width of the stall-cycle performance counter.

Ports:
- `clk`  input  1  clock.
- `rst`  input  1  synchronous, active-high reset.
- `stallreq_id`  input  1  ID stall request (load-use), level, same cycle.
- `stallreq_ex`  input  1  EX stall request, level, same cycle.
- `stallreq_mem`  input  1  MEM stall request (data bus wait), level, same cycle.
- `ex_multi_start`  input  1  one-cycle pulse that starts a counted EX stall.
- `ex_multi_cycles`  input  CNT_W  stall length N for the counted stall; sampled with `ex_multi_start`.
- `flush_req`  input  1  exception/eret flush request, level.
- `flush_pc`  input  32  redirect target, valid with `flush_req`.
- `control`  output  6  stall vector. Bit 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM, 4 = MEM/WB, 5 = WB.
- `flush`  output  1  clears all pipeline registers this edge.
- `new_pc`  output  32  PC redirect target, valid when `flush`=1.
- `ex_multi_done`  output  1  high in the last stall cycle of a counted stall.
- `stall_cycles`  output  PERF_W  count of cycles with `control`≠0.

## Operation
- Register convention, enforced by the consumers: stage register i advances when `control[i]`=0. It inserts a bubble when `control[i]`=1 and `control[i+1]`=0. It holds when both are 1.
- `control` encodings:
  - none: 000000.
  - ID stall: 000111.
  - EX stall: 001111.
  - MEM stall: 011111.
- `control` and `flush` are combinational from the current inputs and registered state; no input-to-register latency.
- Priority (highest first): `rst`, `flush_req`, `stallreq_mem`, EX (`stallreq_ex` OR counted stall active OR `ex_multi_start`), `stallreq_id`.
- Flush:
  - `flush`=1, `new_pc`=`flush_pc`, `control`=000000.
  - The FSM returns to IDLE and the counter clears at the next edge.
  - When `flush_req`=0, `new_pc`=0.
- FSM states:
  - IDLE → MULTI on `ex_multi_start` with N≥2, loading cnt=N-1.
  - MULTI decrements cnt each edge that `stallreq_mem`=0.
  - MULTI → IDLE on the edge where cnt=1, or on flush.
- N=0 is treated as N=1.
- `ex_multi_done`:
  - For N=1, `ex_multi_done` is asserted in the start cycle itself; the FSM stays IDLE.
  - In MULTI, `ex_multi_done`=1 when cnt=1 and `stallreq_mem`=0 and `flush_req`=0.
- `ex_multi_start` while in MULTI is ignored; cnt is not reloaded.
- A MEM stall during MULTI freezes cnt. `control`=011111 takes precedence.
- `stall_cycles` increments on every edge where `control`≠000000. It wraps modulo 2^PERF_W and is not incremented during flush.

## Timing
- Reset values: `control`=000000, `flush`=0, `new_pc`=0, `ex_multi_done`=0, state IDLE, cnt=0, `stall_cycles`=0.
- `rst` has priority over any in-progress counted stall. A reset mid-MULTI aborts the stall with no `ex_multi_done`.
- Counted stall of N cycles, `ex_multi_start` in cycle T, no MEM stall:
  - `control`=001111 in cycles T..T+N-1.
  - `ex_multi_done`=1 in cycle T+N-1 only.
  - `control` is released in cycle T+N unless another request is active.
- Each MEM-stall cycle inside the window extends the counted stall by one cycle.
- Flush in any cycle aborts the counted stall at once, with no `ex_multi_done`.
- `flush_req` and `ex_multi_start` in the same cycle: flush wins and the counted stall is never started.

## Test plan
- Reset then idle: `rst` for 2 cycles, no requests → `control`=000000, `stall_cycles`=0, all outputs 0.
- Single requests, one at a time, each held 1 cycle:
  - `stallreq_id` → 000111.
  - `stallreq_ex` → 001111.
  - `stallreq_mem` → 011111.
  - `stall_cycles`=3 afterwards.
- Priority: `stallreq_id`+`stallreq_mem` together → 011111. Adding `flush_req` with `flush_pc`=0xBFC00380 → `control`=000000, `flush`=1, `new_pc`=0xBFC00380.
- Counted stall, N=4, start at T:
  - `control`=001111 for T..T+3.
  - `ex_multi_done` only at T+3.
  - 000000 at T+4.
  - A second start at T+1 is ignored.
  - N=0 and N=1 → single cycle stall with done at T.
- MEM stall inside counted stall:
  - N=3, `stallreq_mem` at T+1 → 011111 at T+1, 001111 at T+2..T+3.
  - `ex_multi_done` at T+3.
  - `stall_cycles` +4.
- Abort: N=10, `flush_req` at T+2 → `flush`=1 at T+2, `control`=000000 from T+2, no `ex_multi_done`. Repeat with `rst` at T+2 → same, plus `stall_cycles`=0.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush sequencer.
// The master modport is the pipeline side; the slave modport is the sequencer.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  logic              stallreq_id;
  logic              stallreq_ex;
  logic              stallreq_mem;
  logic              ex_multi_start;
  logic [CNT_W-1:0]  ex_multi_cycles;
  logic              flush_req;
  logic [31:0]       flush_pc;
  logic [5:0]        control;
  logic              flush;
  logic [31:0]       new_pc;
  logic              ex_multi_done;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem, ex_multi_start, ex_multi_cycles,
           flush_req, flush_pc,
    input  control, flush, new_pc, ex_multi_done, stall_cycles
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem, ex_multi_start, ex_multi_cycles,
           flush_req, flush_pc,
    output control, flush, new_pc, ex_multi_done, stall_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational control vector,
// counted multi-cycle EX stall, exception redirect and stall-cycle counter.
module pipeline_stall_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);

  typedef enum logic {IDLE, MULTI} state_t;

  localparam logic [5:0] CTRL_NONE = 6'b000000;
  localparam logic [5:0] CTRL_ID   = 6'b000111;
  localparam logic [5:0] CTRL_EX   = 6'b001111;
  localparam logic [5:0] CTRL_MEM  = 6'b011111;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [CNT_W-1:0]    n_eff;
  logic                ex_req;
  logic [5:0]          control;
  logic                flush;
  logic [31:0]         new_pc;
  logic                done;
  logic [PERF_W-1:0]   stall_cycles;

  // A zero-length request still costs the start cycle itself.
  assign n_eff  = (bus.ex_multi_cycles == '0) ? CNT_W'(1) : bus.ex_multi_cycles;
  assign ex_req = bus.stallreq_ex | (state == MULTI) | bus.ex_multi_start;

  always_comb begin
    control  = CTRL_NONE;
    flush    = 1'b0;
    new_pc   = '0;
    done     = 1'b0;
    state_nx = state;
    cnt_nx   = cnt;
    if (rst) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (bus.flush_req) begin
      flush    = 1'b1;
      new_pc   = bus.flush_pc;
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      if (bus.stallreq_mem)     control = CTRL_MEM;
      else if (ex_req)          control = CTRL_EX;
      else if (bus.stallreq_id) control = CTRL_ID;

      unique case (state)
        IDLE: begin
          if (bus.ex_multi_start) begin
            // A MEM stall in the start cycle burns that cycle, so the full N remains.
            if (bus.stallreq_mem) begin
              state_nx = MULTI;
              cnt_nx   = n_eff;
            end else if (n_eff == CNT_W'(1)) begin
              done = 1'b1;
            end else begin
              state_nx = MULTI;
              cnt_nx   = n_eff - CNT_W'(1);
            end
          end
        end
        MULTI: begin
          if (!bus.stallreq_mem) begin
            if (cnt == CNT_W'(1)) begin
              done     = 1'b1;
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      stall_cycles <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (control != CTRL_NONE) stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end

  assign bus.control       = control;
  assign bus.flush         = flush;
  assign bus.new_pc        = new_pc;
  assign bus.ex_multi_done = done;
  assign bus.stall_cycles  = stall_cycles;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector bench for pipeline_stall_ctrl with a queue-based scoreboard:
// the driver pushes the expected outputs of each cycle, the monitor pops and compares.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(6), .PERF_W(32)) bus ();

  pipeline_stall_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          step;
    logic [5:0]  ctrl;
    logic        fl;
    logic [31:0] pc;
    logic        done;
    logic [31:0] sc;
    logic        chk_sc;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          step   = 0;
  logic [31:0] exp_sc = '0;

  localparam logic [5:0]  C0  = 6'b000000;
  localparam logic [5:0]  CID = 6'b000111;
  localparam logic [5:0]  CEX = 6'b001111;
  localparam logic [5:0]  CME = 6'b011111;
  localparam logic [31:0] EPC = 32'hBFC00380;

  // One clock cycle of stimulus plus the outputs expected during that cycle.
  task automatic cyc(input logic r, input logic id, input logic ex, input logic mem,
                     input logic st, input logic [5:0] n, input logic fr,
                     input logic [31:0] fpc, input logic [5:0] ec, input logic ef,
                     input logic [31:0] epc, input logic ed, input logic chk_sc);
    exp_t e;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.stallreq_id     = id;
    bus.stallreq_ex     = ex;
    bus.stallreq_mem    = mem;
    bus.ex_multi_start  = st;
    bus.ex_multi_cycles = n;
    bus.flush_req       = fr;
    bus.flush_pc        = fpc;
    step++;
    e.step = step; e.ctrl = ec; e.fl = ef; e.pc = epc; e.done = ed;
    e.sc = exp_sc; e.chk_sc = chk_sc;
    q.push_back(e);
    if (r) exp_sc = '0;
    else if (ec != C0) exp_sc = exp_sc + 32'd1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0,0,0,0,0,6'd0,0,32'h0, C0,0,32'h0,0,1);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.control !== e.ctrl) begin
        errors++;
        $display("FAIL step%0d control: got %b expected %b", e.step, bus.control, e.ctrl);
      end
      checks++;
      if (bus.flush !== e.fl) begin
        errors++;
        $display("FAIL step%0d flush: got %b expected %b", e.step, bus.flush, e.fl);
      end
      checks++;
      if (bus.new_pc !== e.pc) begin
        errors++;
        $display("FAIL step%0d new_pc: got %h expected %h", e.step, bus.new_pc, e.pc);
      end
      checks++;
      if (bus.ex_multi_done !== e.done) begin
        errors++;
        $display("FAIL step%0d ex_multi_done: got %b expected %b", e.step, bus.ex_multi_done, e.done);
      end
      if (e.chk_sc) begin
        checks++;
        if (bus.stall_cycles !== e.sc) begin
          errors++;
          $display("FAIL step%0d stall_cycles: got %0d expected %0d", e.step, bus.stall_cycles, e.sc);
        end
      end
    end
  end

  initial begin
    bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
    bus.ex_multi_start = 0; bus.ex_multi_cycles = '0;
    bus.flush_req = 0; bus.flush_pc = '0;

    // reset for two cycles, counter unknown until the first reset edge
    cyc(1,0,0,0,0,6'd0,0,32'h0, C0,0,32'h0,0,0);
    cyc(1,0,0,0,0,6'd0,0,32'h0, C0,0,32'h0,0,1);
    idle(2);

    // single requests
    cyc(0,1,0,0,0,6'd0,0,32'h0, CID,0,32'h0,0,1);
    cyc(0,0,1,0,0,6'd0,0,32'h0, CEX,0,32'h0,0,1);
    cyc(0,0,0,1,0,6'd0,0,32'h0, CME,0,32'h0,0,1);
    idle(1);

    // priority: MEM over ID, then flush over everything
    cyc(0,1,0,1,0,6'd0,0,32'h0, CME,0,32'h0,0,1);
    cyc(0,1,0,1,0,6'd0,1,EPC,   C0, 1,EPC,  0,1);
    cyc(0,0,0,0,0,6'd0,0,EPC,   C0, 0,32'h0,0,1);

    // counted stall N=4 with an ignored restart at T+1
    cyc(0,0,0,0,1,6'd4,0,32'h0, CEX,0,32'h0,0,1);
    cyc(0,0,0,0,1,6'd4,0,32'h0, CEX,0,32'h0,0,1);
    cyc(0,0,0,0,0,6'd0,0,32'h0, CEX,0,32'h0,0,1);
    cyc(0,0,0,0,0,6'd0,0,32'h0, CEX,0,32'h0,1,1);
    idle(1);

    // N=0 and N=1 finish in the start cycle
    cyc(0,0,0,0,1,6'd0,0,32'h0, CEX,0,32'h0,1,1);
    idle(1);
    cyc(0,0,0,0,1,6'd1,0,32'h0, CEX,0,32'h0,1,1);
    idle(1);

    // N=3 with a MEM stall at T+1
    cyc(0,0,0,0,1,6'd3,0,32'h0, CEX,0,32'h0,0,1);
    cyc(0,0,0,1,0,6'd0,0,32'h0, CME,0,32'h0,0,1);
    cyc(0,0,0,0,0,6'd0,0,32'h0, CEX,0,32'h0,0,1);
    cyc(0,0,0,0,0,6'd0,0,32'h0, CEX,0,32'h0,1,1);
    idle(1);

    // N=10 aborted by flush at T+2
    cyc(0,0,0,0,1,6'd10,0,32'h0, CEX,0,32'h0,0,1);
    cyc(0,0,0,0,0,6'd0, 0,32'h0, CEX,0,32'h0,0,1);
    cyc(0,0,0,0,0,6'd0, 1,EPC,   C0, 1,EPC,  0,1);
    idle(3);

    // flush and start together: stall never begins
    cyc(0,0,0,0,1,6'd5,1,32'h80000180, C0,1,32'h80000180,0,1);
    idle(2);

    // N=10 aborted by reset at T+2
    cyc(0,0,0,0,1,6'd10,0,32'h0, CEX,0,32'h0,0,1);
    cyc(0,0,0,0,0,6'd0, 0,32'h0, CEX,0,32'h0,0,1);
    cyc(1,0,0,0,0,6'd0, 0,32'h0, C0, 0,32'h0,0,1);
    idle(3);

    @(negedge clk);
    #1;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
